multirate_v2_mac_accum: RTL and testbench



---
 rtl/multirate_v2_pkg.sv | 39 +++
 rtl/multirate_v2_round_sat.sv | 36 +++
 rtl/multirate_v2_mac_accum.sv | 118 +++++++++++
 tb/tb_multirate_v2_mac_accum.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/multirate_v2_pkg.sv
// Shared types and constants for the Multirate_v2 MAC back end.
// round_sat is a generic reference for the round/shift/clamp stage.
package multirate_v2_pkg;

    localparam int PROD_W = 22;
    localparam int OUT_W  = 16;

    typedef enum logic {
        ACC  = 1'b0,
        HOLD = 1'b1
    } state_t;

    typedef struct packed {
        logic             sat;
        logic [OUT_W-1:0] data;
    } rs_t;

    // Round-half-up, arithmetic shift, clamp to the OUT_W signed range.
    function automatic rs_t round_sat(input longint sum, input int shift);
        longint r;
        longint max_v;
        longint min_v;
        rs_t    res;
        max_v = (longint'(1) <<< (OUT_W - 1)) - 1;
        min_v = -max_v - 1;
        r     = (sum + (longint'(1) <<< (shift - 1))) >>> shift;
        res.sat = 1'b1;
        if (r > max_v) begin
            res.data = OUT_W'(max_v);
        end else if (r < min_v) begin
            res.data = OUT_W'(min_v);
        end else begin
            res.data = OUT_W'(r);
            res.sat  = 1'b0;
        end
        return res;
    endfunction

endpackage

// File: rtl/multirate_v2_round_sat.sv
// Combinational round-half-up / arithmetic shift / saturate stage.
// Works one bit wider than the accumulator so the rounding add cannot wrap.
module multirate_v2_round_sat #(
    parameter int ACC_W = 27,
    parameter int OUT_W = multirate_v2_pkg::OUT_W,
    parameter int SHIFT = 6
) (
    input  logic signed [ACC_W-1:0] sum,
    output logic signed [OUT_W-1:0] data,
    output logic                    sat
);

    localparam logic signed [ACC_W:0] HALF  = (ACC_W+1)'(1) << (SHIFT - 1);
    localparam logic signed [ACC_W:0] MAX_V = (ACC_W+1)'((64'd1 << (OUT_W - 1)) - 64'd1);
    localparam logic signed [ACC_W:0] MIN_V = ~MAX_V;

    logic signed [ACC_W:0] ext;
    logic signed [ACC_W:0] rnd;
    logic signed [ACC_W:0] shr;

    always_comb begin
        ext  = {sum[ACC_W-1], sum};
        rnd  = ext + HALF;
        shr  = rnd >>> SHIFT;
        sat  = 1'b0;
        data = shr[OUT_W-1:0];
        if (shr > MAX_V) begin
            data = MAX_V[OUT_W-1:0];
            sat  = 1'b1;
        end else if (shr < MIN_V) begin
            data = MIN_V[OUT_W-1:0];
            sat  = 1'b1;
        end
    end

endmodule

// File: rtl/multirate_v2_mac_accum.sv
// Decimating MAC: sums NUM_TAPS signed products, rounds/shifts/saturates,
// and presents one sample through a one-deep valid/ready output register.
module multirate_v2_mac_accum #(
    parameter int NUM_TAPS = 32,
    parameter int PROD_W   = multirate_v2_pkg::PROD_W,
    parameter int OUT_W    = multirate_v2_pkg::OUT_W,
    parameter int SHIFT    = 6,
    parameter int ACC_W    = PROD_W + $clog2(NUM_TAPS)
) (
    input  logic                     ap_clk,
    input  logic                     ap_rst_n,
    input  logic signed [PROD_W-1:0] prod_tdata,
    input  logic                     prod_tvalid,
    output logic                     prod_tready,
    output logic signed [OUT_W-1:0]  out_tdata,
    output logic                     out_tvalid,
    input  logic                     out_tready,
    output logic [15:0]              sat_count,
    output multirate_v2_pkg::state_t dbg_state
);

    import multirate_v2_pkg::*;

    // Handshakes: a transfer happens on a rising edge where tvalid & tready.
    // Once out_tvalid is high, out_tdata is held until out_tready is seen.

    localparam int TAP_W = $clog2(NUM_TAPS);

    state_t                   state_q;
    state_t                   state_d;
    logic [TAP_W-1:0]         tap_cnt;
    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  prod_ext;
    logic signed [ACC_W-1:0]  sum;
    logic signed [OUT_W-1:0]  rs_data;
    logic                     rs_sat;
    logic signed [OUT_W-1:0]  out_q;
    logic [15:0]              sat_q;
    logic                     accept;
    logic                     last_tap;

    assign prod_ext = {{(ACC_W-PROD_W){prod_tdata[PROD_W-1]}}, prod_tdata};
    assign sum      = acc + prod_ext;
    assign last_tap = (tap_cnt == TAP_W'(NUM_TAPS - 1));

    multirate_v2_round_sat #(
        .ACC_W (ACC_W),
        .OUT_W (OUT_W),
        .SHIFT (SHIFT)
    ) u_round_sat (
        .sum  (sum),
        .data (rs_data),
        .sat  (rs_sat)
    );

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q <= ACC;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        prod_tready = 1'b1;
        out_tvalid  = 1'b0;
        accept      = 1'b0;
        case (state_q)
            ACC: begin
                prod_tready = 1'b1;
                accept      = prod_tvalid;
                if (accept && last_tap) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                out_tvalid  = 1'b1;
                prod_tready = out_tready;
                accept      = prod_tvalid & out_tready;
                if (out_tready) begin
                    state_d = ACC;
                end
            end
            default: state_d = ACC;
        endcase
    end

    // Tap 0 loads rather than adds, so no clear cycle is needed between sums.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            tap_cnt <= '0;
            acc     <= '0;
            out_q   <= '0;
            sat_q   <= '0;
        end else if (accept) begin
            if (tap_cnt == '0) begin
                acc <= prod_ext;
            end else begin
                acc <= sum;
            end
            if (last_tap) begin
                tap_cnt <= '0;
                out_q   <= rs_data;
                if (rs_sat && (sat_q != 16'hFFFF)) begin
                    sat_q <= sat_q + 16'd1;
                end
            end else begin
                tap_cnt <= tap_cnt + TAP_W'(1);
            end
        end
    end

    assign out_tdata = out_q;
    assign sat_count = sat_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_multirate_v2_mac_accum.sv
// Scoreboard bench for multirate_v2_mac_accum: an integer reference model
// predicts each output sample; a negedge monitor pops and compares.
module tb_multirate_v2_mac_accum;

    import multirate_v2_pkg::*;

    localparam int NT = 32;
    localparam int PW = 22;
    localparam int OW = 16;
    localparam int SH = 6;

    logic                 ap_clk = 1'b0;
    logic                 ap_rst_n = 1'b0;
    logic signed [PW-1:0] prod_tdata = '0;
    logic                 prod_tvalid = 1'b0;
    logic                 prod_tready;
    logic signed [OW-1:0] out_tdata;
    logic                 out_tvalid;
    logic                 out_tready = 1'b1;
    logic [15:0]          sat_count;
    state_t               dbg_state;

    multirate_v2_mac_accum #(
        .NUM_TAPS (NT),
        .PROD_W   (PW),
        .OUT_W    (OW),
        .SHIFT    (SH)
    ) dut (
        .ap_clk      (ap_clk),
        .ap_rst_n    (ap_rst_n),
        .prod_tdata  (prod_tdata),
        .prod_tvalid (prod_tvalid),
        .prod_tready (prod_tready),
        .out_tdata   (out_tdata),
        .out_tvalid  (out_tvalid),
        .out_tready  (out_tready),
        .sat_count   (sat_count),
        .dbg_state   (dbg_state)
    );

    // ---------------- clock ----------------
    always #5 ap_clk = ~ap_clk;

    int checks = 0;
    int errors = 0;

    logic [OW-1:0] exp_q[$];
    logic [15:0]   exp_sat_q[$];

    longint acc_m = 0;
    int     tap_m = 0;
    int     sat_m = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // floor((s + 2^(SH-1)) / 2^SH) with plain division
    function automatic longint ref_round(input longint s);
        longint t;
        longint q;
        t = s + (longint'(1) << (SH - 1));
        q = t / (longint'(1) << SH);
        if ((t < 0) && ((t % (longint'(1) << SH)) != 0)) q = q - 1;
        return q;
    endfunction

    task automatic model_tap(input longint p);
        longint r;
        logic   sat;
        rs_t    rs;
        acc_m = acc_m + p;
        tap_m++;
        if (tap_m == NT) begin
            r   = ref_round(acc_m);
            sat = 1'b0;
            if (r > 32767) begin
                r = 32767;
                sat = 1'b1;
            end else if (r < -32768) begin
                r = -32768;
                sat = 1'b1;
            end
            if (sat && sat_m < 65535) sat_m++;
            rs = round_sat(acc_m, SH);
            chk("pkg_round_sat", longint'($signed(rs.data)), r);
            exp_q.push_back(r[OW-1:0]);
            exp_sat_q.push_back(16'(sat_m));
            acc_m = 0;
            tap_m = 0;
        end
    endtask

    function automatic longint rand_prod(input int lim);
        return longint'(int'($urandom_range(0, 2 * lim))) - longint'(lim);
    endfunction

    // ---------------- driver ----------------
    task automatic send(input longint v, input int gap);
        int n;
        n = 0;
        prod_tdata  = PW'(v);
        prod_tvalid = 1'b1;
        forever begin
            @(negedge ap_clk);
            if (prod_tready) break;
            n++;
            if (n > 200) begin
                checks++;
                errors++;
                $display("FAIL send_timeout: prod_tready stuck at 0 for %0d cycles", n);
                prod_tvalid = 1'b0;
                return;
            end
        end
        @(posedge ap_clk);
        #1;
        model_tap(v);
        if (gap > 0) begin
            prod_tvalid = 1'b0;
            repeat (gap) @(posedge ap_clk);
            #1;
        end
    endtask

    task automatic send_sum(input longint target);
        longint s;
        longint v;
        s = 0;
        for (int i = 0; i < NT - 1; i++) begin
            v = rand_prod(100);
            send(v, 0);
            s = s + v;
        end
        send(target - s, 0);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge ap_clk);
            n++;
        end
        #1;
        chk("drain_empty", exp_q.size(), 0);
    endtask

    // ---------------- scoreboard monitor ----------------
    logic          hold_prev = 1'b0;
    logic [OW-1:0] data_prev = '0;
    logic [OW-1:0] e_data;
    logic [15:0]   e_sat;

    always @(negedge ap_clk) begin
        if (!ap_rst_n) begin
            hold_prev = 1'b0;
        end else begin
            if (hold_prev) begin
                chk("hold_valid", longint'(out_tvalid), 1);
                chk("hold_data", longint'(out_tdata), longint'($signed(data_prev)));
            end
            if (out_tvalid && out_tready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got %0d with empty queue", out_tdata);
                end else begin
                    e_data = exp_q.pop_front();
                    e_sat  = exp_sat_q.pop_front();
                    chk("out_tdata", longint'(out_tdata), longint'($signed(e_data)));
                    chk("sat_count", longint'(sat_count), longint'(e_sat));
                end
            end
            hold_prev = out_tvalid && !out_tready;
            data_prev = out_tdata;
        end
    end

    // ---------------- stimulus ----------------
    longint bp_v;

    initial begin
        repeat (3) @(posedge ap_clk);
        #1;
        chk("rst_out_tvalid", longint'(out_tvalid), 0);
        chk("rst_out_tdata", longint'(out_tdata), 0);
        chk("rst_sat_count", longint'(sat_count), 0);
        chk("rst_state", longint'(dbg_state), longint'(ACC));
        ap_rst_n = 1'b1;
        #1;
        chk("rst_prod_tready", longint'(prod_tready), 1);

        // basic sum and latency
        for (int i = 0; i < NT; i++) send(64, 0);
        prod_tvalid = 1'b0;
        chk("latency_valid", longint'(out_tvalid), 1);
        chk("basic_value", longint'(out_tdata), 32);
        @(posedge ap_clk);
        #1;
        chk("valid_drop", longint'(out_tvalid), 0);

        // rounding
        send_sum(95);
        chk("round_95", longint'(out_tdata), 1);
        send_sum(96);
        chk("round_96", longint'(out_tdata), 2);
        send_sum(-97);
        chk("round_m97", longint'(out_tdata), -2);

        // saturation
        for (int i = 0; i < NT; i++) send((longint'(1) << 21) - 1, 0);
        chk("sat_pos_value", longint'(out_tdata), 32767);
        chk("sat_pos_count", longint'(sat_count), 1);
        for (int i = 0; i < NT; i++) send(-(longint'(1) << 21), 0);
        chk("sat_neg_value", longint'(out_tdata), -32768);
        chk("sat_neg_count", longint'(sat_count), 2);
        prod_tvalid = 1'b0;
        drain();

        // backpressure
        out_tready = 1'b0;
        for (int i = 0; i < NT; i++) send(rand_prod(1000), 0);
        bp_v        = rand_prod(1000);
        prod_tdata  = PW'(bp_v);
        prod_tvalid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge ap_clk);
            chk("bp_prod_tready", longint'(prod_tready), 0);
            chk("bp_out_tvalid", longint'(out_tvalid), 1);
        end
        @(posedge ap_clk);
        #1;
        out_tready = 1'b1;
        send(bp_v, 0);
        for (int i = 1; i < NT; i++) send(rand_prod(1000), 0);
        prod_tvalid = 1'b0;
        drain();

        // streaming with random gaps
        for (int s = 0; s < 4; s++) begin
            for (int i = 0; i < NT; i++) begin
                send(rand_prod((s == 0) ? ((1 << 21) - 1) : (1 << 17)),
                     int'($urandom_range(0, 2)));
            end
        end
        prod_tvalid = 1'b0;
        drain();

        // reset mid-sample
        for (int i = 0; i < 17; i++) send(rand_prod(5000), 0);
        prod_tvalid = 1'b0;
        ap_rst_n    = 1'b0;
        #1;
        chk("midrst_out_tvalid", longint'(out_tvalid), 0);
        chk("midrst_sat_count", longint'(sat_count), 0);
        chk("midrst_state", longint'(dbg_state), longint'(ACC));
        acc_m = 0;
        tap_m = 0;
        sat_m = 0;
        @(posedge ap_clk);
        #1;
        ap_rst_n = 1'b1;
        for (int i = 0; i < NT; i++) send(64, 0);
        prod_tvalid = 1'b0;
        chk("post_rst_value", longint'(out_tdata), 32);
        drain();

        // ---------------- report ----------------
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
